// File: rtl/id_ex_alu_stage.sv
// id_ex_alu_stage
//   ID/EX pipeline register and ALU front end for the 32-bit bit-slice ALU.
//   Latches the decoded instruction from ID, turns alu_op/funct into slice
//   controls (sel, binvert/cin), applies EX-stage operand forwarding and
//   drives the ALU operand buses. Supports stall (hold) and flush (bubble).
//
// Ports
//   clk, rst                  clock; synchronous active-high reset
//   stall, flush              hold ID/EX contents / insert a bubble
//   in_valid                  ID holds a real instruction
//   in_alu_op, in_funct       ALU operation class and R-type funct
//   in_rs_data, in_rt_data    register-file read data
//   in_imm, in_alu_src        sign-extended immediate and operand-B select
//   in_rs, in_rt, in_rd       register numbers; in_reg_dst picks rd vs rt
//   in_reg_write, in_mem_read, in_mem_write, in_mem_to_reg
//                             control bits carried toward MEM/WB
//   fwd_a, fwd_b              forwarding selects (00 reg, 10 EX/MEM, 01 MEM/WB)
//   exmem_result, memwb_result
//                             forwarded results
//   alu_a, alu_b              ALU operands
//   alu_sel, alu_binvert      slice mux select and B-invert / LSB carry-in
//   ex_valid, ex_illegal      EX-stage valid and unsupported-op flag
//   ex_store_data             forwarded rt value for stores
//   ex_dest, ex_rs, ex_rt     destination and source register numbers
//   ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg
//                             registered controls, gated by validity
module id_ex_alu_stage #(
  parameter int WIDTH  = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [1:0]        in_alu_op,
  input  logic [5:0]        in_funct,
  input  logic [WIDTH-1:0]  in_rs_data,
  input  logic [WIDTH-1:0]  in_rt_data,
  input  logic [WIDTH-1:0]  in_imm,
  input  logic              in_alu_src,
  input  logic [REG_AW-1:0] in_rs,
  input  logic [REG_AW-1:0] in_rt,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_reg_dst,
  input  logic              in_reg_write,
  input  logic              in_mem_read,
  input  logic              in_mem_write,
  input  logic              in_mem_to_reg,
  input  logic [1:0]        fwd_a,
  input  logic [1:0]        fwd_b,
  input  logic [WIDTH-1:0]  exmem_result,
  input  logic [WIDTH-1:0]  memwb_result,
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  output logic [1:0]        alu_sel,
  output logic              alu_binvert,
  output logic              ex_valid,
  output logic [WIDTH-1:0]  ex_store_data,
  output logic [REG_AW-1:0] ex_dest,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_mem_to_reg,
  output logic [REG_AW-1:0] ex_rs,
  output logic [REG_AW-1:0] ex_rt,
  output logic              ex_illegal
);

  typedef struct packed {
    logic [1:0] sel;
    logic       binv;
    logic       legal;
  } dec_t;

  // Unsupported operations fall back to a plain add so the ALU still sees a
  // well-defined control word; legality is reported separately.
  function automatic dec_t alu_decode(input logic [1:0] op, input logic [5:0] funct);
    dec_t d;
    d = '{sel: 2'b10, binv: 1'b0, legal: 1'b1};
    case (op)
      2'b00: d.binv = 1'b0;
      2'b01: d.binv = 1'b1;
      2'b10: begin
        case (funct)
          6'b100000: d.binv = 1'b0;
          6'b100010: d.binv = 1'b1;
          6'b100100: d.sel  = 2'b00;
          6'b100101: d.sel  = 2'b01;
          6'b101010: begin
            d.sel  = 2'b11;
            d.binv = 1'b1;
          end
          default:   d.legal = 1'b0;
        endcase
      end
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

  // Select 11 is unused by the hazard unit and behaves like 00.
  function automatic logic signed [WIDTH-1:0] fwd_mux(
    input logic [1:0]              sel,
    input logic signed [WIDTH-1:0] regv,
    input logic signed [WIDTH-1:0] exmem,
    input logic signed [WIDTH-1:0] memwb
  );
    case (sel)
      2'b10:   return exmem;
      2'b01:   return memwb;
      default: return regv;
    endcase
  endfunction

  dec_t dec_p0;
  assign dec_p0 = alu_decode(in_alu_op, in_funct);

  logic                     vld_p1;
  logic                     reg_write_p1, mem_read_p1, mem_write_p1, mem_to_reg_p1;
  logic [1:0]               sel_p1;
  logic                     binv_p1, illegal_p1;
  logic signed [WIDTH-1:0]  rs_data_p1, rt_data_p1, imm_p1;
  logic                     alu_src_p1;
  logic [REG_AW-1:0]        rs_p1, rt_p1, dest_p1;

  // ---- ID -> EX register boundary ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1        <= 1'b0;
      reg_write_p1  <= 1'b0;
      mem_read_p1   <= 1'b0;
      mem_write_p1  <= 1'b0;
      mem_to_reg_p1 <= 1'b0;
      sel_p1        <= 2'b00;
      binv_p1       <= 1'b0;
      illegal_p1    <= 1'b0;
      rs_data_p1    <= '0;
      rt_data_p1    <= '0;
      imm_p1        <= '0;
      alu_src_p1    <= 1'b0;
      rs_p1         <= '0;
      rt_p1         <= '0;
      dest_p1       <= '0;
    end else if (flush) begin
      // Bubble: only controls matter, data fields are left as they were.
      vld_p1        <= 1'b0;
      reg_write_p1  <= 1'b0;
      mem_read_p1   <= 1'b0;
      mem_write_p1  <= 1'b0;
      mem_to_reg_p1 <= 1'b0;
      sel_p1        <= 2'b00;
      binv_p1       <= 1'b0;
      illegal_p1    <= 1'b0;
    end else if (!stall) begin
      // An invalid slot loads exactly like a bubble on the control side.
      vld_p1        <= in_valid;
      reg_write_p1  <= in_valid & in_reg_write & dec_p0.legal;
      mem_read_p1   <= in_valid & in_mem_read;
      mem_write_p1  <= in_valid & in_mem_write & dec_p0.legal;
      mem_to_reg_p1 <= in_valid & in_mem_to_reg;
      sel_p1        <= in_valid ? dec_p0.sel : 2'b00;
      binv_p1       <= in_valid & dec_p0.binv;
      illegal_p1    <= in_valid & ~dec_p0.legal;
      rs_data_p1    <= in_rs_data;
      rt_data_p1    <= in_rt_data;
      imm_p1        <= in_imm;
      alu_src_p1    <= in_alu_src;
      rs_p1         <= in_rs;
      rt_p1         <= in_rt;
      dest_p1       <= in_reg_dst ? in_rd : in_rt;
    end
  end

  // ---- EX operand forwarding (combinational on registered data) ----
  logic signed [WIDTH-1:0] fa_p1, fb_p1;
  assign fa_p1 = fwd_mux(fwd_a, rs_data_p1, exmem_result, memwb_result);
  assign fb_p1 = fwd_mux(fwd_b, rt_data_p1, exmem_result, memwb_result);

  assign alu_a         = fa_p1;
  assign alu_b         = alu_src_p1 ? imm_p1 : fb_p1;
  assign ex_store_data = fb_p1;
  assign alu_sel       = sel_p1;
  assign alu_binvert   = binv_p1;
  assign ex_valid      = vld_p1;
  assign ex_dest       = dest_p1;
  assign ex_reg_write  = reg_write_p1;
  assign ex_mem_read   = mem_read_p1;
  assign ex_mem_write  = mem_write_p1;
  assign ex_mem_to_reg = mem_to_reg_p1;
  assign ex_rs         = rs_p1;
  assign ex_rt         = rt_p1;
  assign ex_illegal    = illegal_p1;

endmodule

// File: tb/tb_id_ex_alu_stage.sv
module tb_id_ex_alu_stage;
  localparam int WIDTH  = 32;
  localparam int REG_AW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, stall, flush, in_valid;
  logic [1:0]        in_alu_op;
  logic [5:0]        in_funct;
  logic [WIDTH-1:0]  in_rs_data, in_rt_data, in_imm;
  logic              in_alu_src;
  logic [REG_AW-1:0] in_rs, in_rt, in_rd;
  logic              in_reg_dst, in_reg_write, in_mem_read, in_mem_write, in_mem_to_reg;
  logic [1:0]        fwd_a, fwd_b;
  logic [WIDTH-1:0]  exmem_result, memwb_result;
  logic [WIDTH-1:0]  alu_a, alu_b, ex_store_data;
  logic [1:0]        alu_sel;
  logic              alu_binvert, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
  logic              ex_mem_to_reg, ex_illegal;
  logic [REG_AW-1:0] ex_dest, ex_rs, ex_rt;

  id_ex_alu_stage #(.WIDTH(WIDTH), .REG_AW(REG_AW)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
    .in_alu_op(in_alu_op), .in_funct(in_funct), .in_rs_data(in_rs_data),
    .in_rt_data(in_rt_data), .in_imm(in_imm), .in_alu_src(in_alu_src),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_reg_dst(in_reg_dst),
    .in_reg_write(in_reg_write), .in_mem_read(in_mem_read),
    .in_mem_write(in_mem_write), .in_mem_to_reg(in_mem_to_reg),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .exmem_result(exmem_result),
    .memwb_result(memwb_result), .alu_a(alu_a), .alu_b(alu_b),
    .alu_sel(alu_sel), .alu_binvert(alu_binvert), .ex_valid(ex_valid),
    .ex_store_data(ex_store_data), .ex_dest(ex_dest), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_illegal(ex_illegal)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference: the instruction currently sitting in EX, as the programmer sees it.
  typedef struct {
    logic              valid;
    logic [1:0]        op;
    logic [5:0]        funct;
    logic [WIDTH-1:0]  rs_d, rt_d, imm;
    logic              src;
    logic [REG_AW-1:0] rs, rt, dest;
    logic              rw, mr, mw, m2r;
    logic              data_known;
  } ex_t;
  ex_t m;

  typedef struct packed {
    logic [1:0]       sel;
    logic             binv, ill, rw, mr, mw, m2r;
    logic [WIDTH-1:0] a, b, sd;
  } exp_t;

  function automatic logic [WIDTH-1:0] fwd_pick(input logic [1:0] s, input logic [WIDTH-1:0] regv);
    if (s == 2'b10) return exmem_result;
    if (s == 2'b01) return memwb_result;
    return regv;
  endfunction

  // Instruction semantics: add -> sum, sub/beq -> sum with inverted B,
  // and/or -> logic slices, slt -> less with inverted B, anything else illegal.
  function automatic exp_t model_out();
    exp_t e;
    logic [WIDTH-1:0] fb;
    logic legal;
    e = '0;
    legal = 1'b1;
    if (m.valid) begin
      e.sel = 2'd2;
      if (m.op == 2'b01) e.binv = 1'b1;
      else if (m.op == 2'b11) legal = 1'b0;
      else if (m.op == 2'b10) begin
        if (m.funct == 6'h22) e.binv = 1'b1;
        else if (m.funct == 6'h24) e.sel = 2'd0;
        else if (m.funct == 6'h25) e.sel = 2'd1;
        else if (m.funct == 6'h2A) begin e.sel = 2'd3; e.binv = 1'b1; end
        else if (m.funct != 6'h20) legal = 1'b0;
      end
      e.ill = !legal;
      e.rw  = m.rw && legal;
      e.mw  = m.mw && legal;
      e.mr  = m.mr;
      e.m2r = m.m2r;
    end
    e.a  = fwd_pick(fwd_a, m.rs_d);
    fb   = fwd_pick(fwd_b, m.rt_d);
    e.b  = m.src ? m.imm : fb;
    e.sd = fb;
    return e;
  endfunction

  task automatic model_edge();
    if (rst) begin
      m = '{default: '0};
      m.data_known = 1'b1;
    end else if (flush) begin
      m.valid = 1'b0;
      m.data_known = 1'b0;
    end else if (!stall) begin
      m.valid = in_valid;  m.op = in_alu_op;  m.funct = in_funct;
      m.rs_d = in_rs_data; m.rt_d = in_rt_data; m.imm = in_imm; m.src = in_alu_src;
      m.rs = in_rs; m.rt = in_rt; m.dest = in_reg_dst ? in_rd : in_rt;
      m.rw = in_reg_write; m.mr = in_mem_read; m.mw = in_mem_write; m.m2r = in_mem_to_reg;
      m.data_known = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic rand_inputs();
    logic [5:0] ftab [5];
    int k;
    ftab = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    in_valid = ($urandom_range(0, 3) != 0);
    in_alu_op = 2'($urandom_range(0, 3));
    k = $urandom_range(0, 5);
    in_funct = (k == 5) ? 6'($urandom) : ftab[k];
    in_rs_data = $urandom; in_rt_data = $urandom; in_imm = $urandom;
    in_alu_src = ($urandom_range(0, 1) == 1);
    in_rs = REG_AW'($urandom); in_rt = REG_AW'($urandom); in_rd = REG_AW'($urandom);
    in_reg_dst = ($urandom_range(0, 1) == 1);
    in_reg_write = ($urandom_range(0, 1) == 1);
    in_mem_read = ($urandom_range(0, 1) == 1);
    in_mem_write = ($urandom_range(0, 1) == 1);
    in_mem_to_reg = ($urandom_range(0, 1) == 1);
    fwd_a = 2'($urandom_range(0, 3)); fwd_b = 2'($urandom_range(0, 3));
    exmem_result = $urandom; memwb_result = $urandom;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rand_inputs();
      stall = ($urandom_range(0, 1) == 1);
      flush = ($urandom_range(0, 1) == 1);
      fwd_a = 2'b00; fwd_b = 2'b00;
      tick();
      n_tests++;
      if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || alu_sel !== 2'b00 ||
          alu_a !== '0 || alu_b !== '0 || ex_dest !== '0 || ex_illegal !== 1'b0) begin
        n_fail++;
        $display("FAIL reset[%0d]: got valid=%b rw=%b sel=%b a=%h b=%h dest=%0d ill=%b, want all 0",
                 i, ex_valid, ex_reg_write, alu_sel, alu_a, alu_b, ex_dest, ex_illegal);
      end
    end
    rst = 1'b0; stall = 1'b0; flush = 1'b0;
    rand_inputs();
    in_valid = 1'b0; in_rs_data = '0; in_rt_data = '0; in_imm = '0;
    fwd_a = 2'b00; fwd_b = 2'b00;
    tick();
    n_tests++;
    if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || alu_sel !== 2'b00 ||
        alu_binvert !== 1'b0 || alu_a !== '0 || ex_mem_write !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: got valid=%b rw=%b sel=%b binv=%b a=%h mw=%b, want all 0",
               ex_valid, ex_reg_write, alu_sel, alu_binvert, alu_a, ex_mem_write);
    end
  endtask

  task automatic test_rtype_sub();
    rand_inputs();
    in_valid = 1'b1; in_alu_op = 2'b10; in_funct = 6'b100010;
    in_rs_data = 32'd7; in_rt_data = 32'd3; in_rd = 5'd9; in_reg_dst = 1'b1;
    in_alu_src = 1'b0; in_reg_write = 1'b1; fwd_a = 2'b00; fwd_b = 2'b00;
    tick();
    n_tests++;
    if (alu_sel !== 2'b10 || alu_binvert !== 1'b1 || alu_a !== 32'd7 || alu_b !== 32'd3 ||
        ex_dest !== 5'd9 || ex_reg_write !== 1'b1 || ex_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL rtype_sub: got sel=%b binv=%b a=%0d b=%0d dest=%0d rw=%b v=%b, want 10 1 7 3 9 1 1",
               alu_sel, alu_binvert, alu_a, alu_b, ex_dest, ex_reg_write, ex_valid);
    end
  endtask

  task automatic test_slt_fwd();
    logic [WIDTH-1:0] rsd;
    rand_inputs();
    rsd = in_rs_data;
    in_valid = 1'b1; in_alu_op = 2'b10; in_funct = 6'b101010; in_alu_src = 1'b0;
    fwd_a = 2'b10; exmem_result = 32'hFFFF_FFFF; fwd_b = 2'b01; memwb_result = 32'd5;
    tick();
    n_tests++;
    if (alu_a !== 32'hFFFF_FFFF || alu_b !== 32'd5 || alu_sel !== 2'b11 || alu_binvert !== 1'b1) begin
      n_fail++;
      $display("FAIL slt_fwd: got a=%h b=%h sel=%b binv=%b, want ffffffff 00000005 11 1",
               alu_a, alu_b, alu_sel, alu_binvert);
    end
    fwd_a = 2'b11;
    #1;
    n_tests++;
    if (alu_a !== rsd) begin
      n_fail++;
      $display("FAIL fwd_11_as_reg: got a=%h want %h", alu_a, rsd);
    end
  endtask

  task automatic test_sw();
    rand_inputs();
    in_valid = 1'b1; in_alu_op = 2'b00; in_alu_src = 1'b1; in_imm = 32'hFFFF_FFFC;
    in_rt_data = 32'h1234; in_mem_write = 1'b1; in_reg_write = 1'b0; in_mem_read = 1'b0;
    fwd_b = 2'b00;
    tick();
    n_tests++;
    if (alu_b !== 32'hFFFF_FFFC || ex_store_data !== 32'h1234 || ex_mem_write !== 1'b1 ||
        ex_reg_write !== 1'b0 || alu_sel !== 2'b10 || alu_binvert !== 1'b0) begin
      n_fail++;
      $display("FAIL sw: got b=%h sd=%h mw=%b rw=%b sel=%b binv=%b, want fffffffc 00001234 1 0 10 0",
               alu_b, ex_store_data, ex_mem_write, ex_reg_write, alu_sel, alu_binvert);
    end
    fwd_b = 2'b10; exmem_result = 32'hABCD_0001;
    #1;
    n_tests++;
    if (ex_store_data !== 32'hABCD_0001 || alu_b !== 32'hFFFF_FFFC) begin
      n_fail++;
      $display("FAIL sw_fwd_store: got sd=%h b=%h, want abcd0001 fffffffc", ex_store_data, alu_b);
    end
  endtask

  task automatic test_stall_flush();
    rand_inputs();
    in_valid = 1'b1; in_alu_op = 2'b10; in_funct = 6'b100000; in_alu_src = 1'b0;
    in_rs_data = 32'd100; in_rt_data = 32'd23; in_rd = 5'd5; in_reg_dst = 1'b1;
    in_reg_write = 1'b1; in_mem_write = 1'b0; fwd_a = 2'b00; fwd_b = 2'b00;
    tick();
    for (int i = 0; i < 3; i++) begin
      rand_inputs();
      stall = 1'b1; fwd_a = 2'b00; fwd_b = 2'b00;
      tick();
      n_tests++;
      if (ex_valid !== 1'b1 || alu_a !== 32'd100 || alu_b !== 32'd23 || ex_dest !== 5'd5 ||
          alu_sel !== 2'b10 || alu_binvert !== 1'b0 || ex_reg_write !== 1'b1) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: got v=%b a=%0d b=%0d dest=%0d sel=%b binv=%b rw=%b, want 1 100 23 5 10 0 1",
                 i, ex_valid, alu_a, alu_b, ex_dest, alu_sel, alu_binvert, ex_reg_write);
      end
    end
    fwd_a = 2'b10; exmem_result = 32'h55AA_55AA;
    #1;
    n_tests++;
    if (alu_a !== 32'h55AA_55AA) begin
      n_fail++;
      $display("FAIL stall_fwd_live: got a=%h want 55aa55aa", alu_a);
    end
    rand_inputs();
    in_valid = 1'b1; in_reg_write = 1'b1; in_mem_read = 1'b1; in_mem_write = 1'b1;
    in_mem_to_reg = 1'b1; stall = 1'b1; flush = 1'b1;
    tick();
    n_tests++;
    if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || ex_mem_read !== 1'b0 ||
        ex_mem_write !== 1'b0 || ex_mem_to_reg !== 1'b0 || ex_illegal !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_over_stall: got v=%b rw=%b mr=%b mw=%b m2r=%b ill=%b, want all 0",
               ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_illegal);
    end
    stall = 1'b0; flush = 1'b0;
  endtask

  task automatic test_illegal();
    rand_inputs();
    in_valid = 1'b1; in_alu_op = 2'b10; in_funct = 6'b000111;
    in_reg_write = 1'b1; in_mem_write = 1'b1;
    tick();
    n_tests++;
    if (ex_illegal !== 1'b1 || ex_reg_write !== 1'b0 || ex_mem_write !== 1'b0 ||
        alu_sel !== 2'b10 || alu_binvert !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_funct: got ill=%b rw=%b mw=%b sel=%b binv=%b, want 1 0 0 10 0",
               ex_illegal, ex_reg_write, ex_mem_write, alu_sel, alu_binvert);
    end
    rand_inputs();
    in_valid = 1'b1; in_alu_op = 2'b10; in_funct = 6'b100101; in_reg_write = 1'b1;
    tick();
    n_tests++;
    if (ex_illegal !== 1'b0 || alu_sel !== 2'b01 || ex_reg_write !== 1'b1) begin
      n_fail++;
      $display("FAIL illegal_clears: got ill=%b sel=%b rw=%b, want 0 01 1", ex_illegal, alu_sel, ex_reg_write);
    end
    rand_inputs();
    in_valid = 1'b1; in_alu_op = 2'b11; in_reg_write = 1'b1;
    tick();
    n_tests++;
    if (ex_illegal !== 1'b1 || ex_reg_write !== 1'b0 || alu_sel !== 2'b10) begin
      n_fail++;
      $display("FAIL illegal_op11: got ill=%b rw=%b sel=%b, want 1 0 10", ex_illegal, ex_reg_write, alu_sel);
    end
    rand_inputs();
    in_valid = 1'b0; in_alu_op = 2'b11;
    tick();
    n_tests++;
    if (ex_illegal !== 1'b0 || ex_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_invalid: got ill=%b v=%b, want 0 0", ex_illegal, ex_valid);
    end
  endtask

  task automatic test_random();
    exp_t e;
    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      rst   = ($urandom_range(0, 39) == 0);
      flush = ($urandom_range(0, 7) == 0);
      stall = ($urandom_range(0, 4) == 0);
      tick();
      e = model_out();
      n_tests++;
      if (ex_valid !== m.valid || alu_sel !== e.sel || alu_binvert !== e.binv ||
          ex_illegal !== e.ill || ex_reg_write !== e.rw || ex_mem_read !== e.mr ||
          ex_mem_write !== e.mw || ex_mem_to_reg !== e.m2r) begin
        n_fail++;
        $display("FAIL random_ctrl[%0d]: got v%b s%b bi%b il%b rw%b mr%b mw%b m2r%b, want v%b s%b bi%b il%b rw%b mr%b mw%b m2r%b",
                 i, ex_valid, alu_sel, alu_binvert, ex_illegal, ex_reg_write, ex_mem_read,
                 ex_mem_write, ex_mem_to_reg, m.valid, e.sel, e.binv, e.ill, e.rw, e.mr, e.mw, e.m2r);
      end
      if (m.data_known) begin
        n_tests++;
        if (alu_a !== e.a || alu_b !== e.b || ex_store_data !== e.sd ||
            ex_dest !== m.dest || ex_rs !== m.rs || ex_rt !== m.rt) begin
          n_fail++;
          $display("FAIL random_data[%0d]: got a=%h b=%h sd=%h d=%0d rs=%0d rt=%0d, want a=%h b=%h sd=%h d=%0d rs=%0d rt=%0d",
                   i, alu_a, alu_b, ex_store_data, ex_dest, ex_rs, ex_rt,
                   e.a, e.b, e.sd, m.dest, m.rs, m.rt);
        end
      end
    end
    rst = 1'b0; stall = 1'b0; flush = 1'b0;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    rand_inputs();
    test_reset();
    test_rtype_sub();
    test_slt_fwd();
    test_sw();
    test_stall_flush();
    test_illegal();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
